// File: rtl/fetch_redirect_pkg.sv
// Shared pipeline types for the fetch stage.
// Holds the instruction-bus request/response structs, the fetch FSM state
// enum, the reset PC default and the held-instruction record.
package fetch_redirect_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_DISCARD,
    ST_HOLD
  } fetch_state_t;

  localparam logic [63:0] PCINIT_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  // Instructions are word aligned, so the two low address bits are dropped.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// Fetch-stage bundle: instruction-bus request/response plus the
// valid/ready handoff of the fetched instruction to decode.
// master = the fetch unit, slave = the bus/decode side.
interface fetch_redirect_if;
  import fetch_redirect_pkg::*;

  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output ireq,
    input  iresp,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  ireq,
    output iresp,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface

// File: rtl/fetch_redirect.sv
// Instruction fetch with branch redirect.
// Issues one bus request at a time from the PC register, holds the returned
// instruction until decode takes it, and restarts at redirect targets while
// making sure nothing fetched from a stale PC ever reaches decode.
// Optional macro FETCH_PERF_EN adds perf_fetch / perf_flush counters.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [63:0]      redirect_pc,
  fetch_redirect_if.master fif
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]      perf_fetch,
  output logic [63:0]      perf_flush
`endif
);

  fetch_state_t state;
  logic [63:0]  pc;
  logic [63:0]  pend_pc;
  fetch_data_t  held;
  logic [63:0]  target_pc;
  logic         data_ok;

  assign target_pc = align_pc(redirect_pc);
  assign data_ok   = fif.iresp.data_ok;

  // The request address is the PC register itself, which only changes on
  // data_ok or while no request is raised, so a raised request never moves.
  assign fif.ireq.valid = (state != ST_HOLD);
  assign fif.ireq.addr  = pc;
  assign fif.out_valid  = held.valid;
  assign fif.out_pc     = held.pc;
  assign fif.out_instr  = held.instr;

  // Fetch FSM: request, discard a stale response, or hold for decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_REQ;
      pc      <= PCINIT;
      pend_pc <= '0;
      held    <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (redirect && data_ok) begin
            pc <= target_pc;
          end else if (redirect) begin
            pend_pc <= target_pc;
            state   <= ST_DISCARD;
          end else if (data_ok) begin
            held.valid <= 1'b1;
            held.pc    <= pc;
            held.instr <= fif.iresp.data;
            state      <= ST_HOLD;
          end
        end
        ST_DISCARD: begin
          if (redirect && data_ok) begin
            pc    <= target_pc;
            state <= ST_REQ;
          end else if (redirect) begin
            pend_pc <= target_pc;
          end else if (data_ok) begin
            pc    <= pend_pc;
            state <= ST_REQ;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            held.valid <= 1'b0;
            pc         <= target_pc;
            state      <= ST_REQ;
          end else if (fif.out_ready) begin
            held.valid <= 1'b0;
            pc         <= pc + 64'd4;
            state      <= ST_REQ;
          end
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic accept_evt;
  logic flush_evt;

  assign accept_evt = (state == ST_HOLD) && !redirect && fif.out_ready;
  assign flush_evt  = ((state == ST_HOLD) && redirect) ||
                      ((state == ST_REQ) && redirect && data_ok) ||
                      ((state == ST_DISCARD) && data_ok);

  // Free-running event counters for accepted and flushed fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch <= '0;
      perf_flush <= '0;
    end else begin
      if (accept_evt) perf_fetch <= perf_fetch + 64'd1;
      if (flush_evt)  perf_flush <= perf_flush + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: reset, normal fetch, decode stall,
// redirect in every state, PC wrap, and reset during a discarded request.
module tb_fetch_redirect;
  import fetch_redirect_pkg::*;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  int          vec_count;
  int          miss_count;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetch;
  logic [63:0] perf_flush;
  logic [63:0] flush_before;
`endif

  fetch_redirect_if fif ();

  fetch_redirect dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fif         (fif.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_flush  (perf_flush)
`endif
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic rd, input logic [63:0] rpc,
                                input logic ok, input logic [31:0] data,
                                input logic rdy);
    redirect           = rd;
    redirect_pc        = rpc;
    fif.iresp.data_ok  = ok;
    fif.iresp.data     = data;
    fif.out_ready      = rdy;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      miss_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed test sequence
  initial begin
    vec_count  = 0;
    miss_count = 0;
    reset      = 1'b0;
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick();

    check_output("rst_out_valid", {63'h0, fif.out_valid}, 64'h0);
    check_output("rst_out_pc", fif.out_pc, 64'h0);
    check_output("rst_out_instr", {32'h0, fif.out_instr}, 64'h0);
    check_output("rst_addr", fif.ireq.addr, 64'h8000_0000);

    reset = 1'b1;
    check_output("first_req_valid", {63'h0, fif.ireq.valid}, 64'h1);
    check_output("first_req_addr", fif.ireq.addr, 64'h8000_0000);
    tick();
    check_output("req_addr_stable", fif.ireq.addr, 64'h8000_0000);

    apply_stimulus(1'b0, 64'h0, 1'b1, 32'h0000_0013, 1'b1);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_output("hold_valid", {63'h0, fif.out_valid}, 64'h1);
    check_output("hold_pc", fif.out_pc, 64'h8000_0000);
    check_output("hold_instr", {32'h0, fif.out_instr}, 64'h13);
    check_output("hold_no_req", {63'h0, fif.ireq.valid}, 64'h0);
    tick();
    check_output("next_addr", fif.ireq.addr, 64'h8000_0004);
    check_output("accepted_clears", {63'h0, fif.out_valid}, 64'h0);

    $display("[TB] decode stall");
    apply_stimulus(1'b0, 64'h0, 1'b1, 32'h0010_0093, 1'b0);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_output("stall_valid", {63'h0, fif.out_valid}, 64'h1);
      check_output("stall_pc", fif.out_pc, 64'h8000_0004);
      check_output("stall_instr", {32'h0, fif.out_instr}, 64'h0010_0093);
      check_output("stall_no_req", {63'h0, fif.ireq.valid}, 64'h0);
      tick();
    end
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    tick();
    check_output("addr_after_stall", fif.ireq.addr, 64'h8000_0008);

    $display("[TB] redirect while request pending");
    apply_stimulus(1'b1, 64'h8000_0100, 1'b0, 32'h0, 1'b1);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_output("discard_addr", fif.ireq.addr, 64'h8000_0008);
    check_output("discard_req", {63'h0, fif.ireq.valid}, 64'h1);
    check_output("discard_out0", {63'h0, fif.out_valid}, 64'h0);
    tick();
    check_output("discard_out1", {63'h0, fif.out_valid}, 64'h0);
    apply_stimulus(1'b0, 64'h0, 1'b1, 32'hdead_beef, 1'b1);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_output("stale_dropped", {63'h0, fif.out_valid}, 64'h0);
    check_output("redir_addr", fif.ireq.addr, 64'h8000_0100);
    check_output("redir_req", {63'h0, fif.ireq.valid}, 64'h1);

    $display("[TB] redirect with data_ok");
    apply_stimulus(1'b1, 64'h8000_0200, 1'b1, 32'hcafe_f00d, 1'b1);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_output("same_cycle_drop", {63'h0, fif.out_valid}, 64'h0);
    check_output("same_cycle_addr", fif.ireq.addr, 64'h8000_0200);
    check_output("same_cycle_req", {63'h0, fif.ireq.valid}, 64'h1);
    tick();
    check_output("same_cycle_drop2", {63'h0, fif.out_valid}, 64'h0);

    $display("[TB] two redirects while discarding");
`ifdef FETCH_PERF_EN
    flush_before = perf_flush;
`endif
    apply_stimulus(1'b1, 64'h8000_0300, 1'b0, 32'h0, 1'b1);
    tick();
    apply_stimulus(1'b1, 64'h8000_0400, 1'b0, 32'h0, 1'b1);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_output("double_hold_addr", fif.ireq.addr, 64'h8000_0200);
    apply_stimulus(1'b0, 64'h0, 1'b1, 32'h1111_1111, 1'b1);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_output("last_redirect_wins", fif.ireq.addr, 64'h8000_0400);
    check_output("double_drop", {63'h0, fif.out_valid}, 64'h0);
`ifdef FETCH_PERF_EN
    check_output("perf_flush_inc", perf_flush, flush_before + 64'd1);
`endif

    $display("[TB] redirect while holding");
    apply_stimulus(1'b0, 64'h0, 1'b1, 32'h0000_0abc, 1'b0);
    tick();
    apply_stimulus(1'b1, 64'h8000_0503, 1'b0, 32'h0, 1'b1);
    check_output("hold2_valid", {63'h0, fif.out_valid}, 64'h1);
    check_output("hold2_pc", fif.out_pc, 64'h8000_0400);
    check_output("hold2_instr", {32'h0, fif.out_instr}, 64'habc);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check_output("hold_redir_drop", {63'h0, fif.out_valid}, 64'h0);
    check_output("hold_redir_aligned", fif.ireq.addr, 64'h8000_0500);
    check_output("hold_redir_req", {63'h0, fif.ireq.valid}, 64'h1);

    $display("[TB] PC wrap");
    apply_stimulus(1'b1, 64'hffff_ffff_ffff_fffe, 1'b1, 32'h0, 1'b0);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b1, 32'h0000_0073, 1'b0);
    check_output("wrap_addr", fif.ireq.addr, 64'hffff_ffff_ffff_fffc);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_output("wrap_hold_pc", fif.out_pc, 64'hffff_ffff_ffff_fffc);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check_output("wrap_next_addr", fif.ireq.addr, 64'h0);

    $display("[TB] reset while discarding");
    apply_stimulus(1'b1, 64'h8000_0600, 1'b0, 32'h0, 1'b0);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check_output("pre_reset_addr", fif.ireq.addr, 64'h0);
    #2 reset = 1'b0;
    #1;
    check_output("async_out_valid", {63'h0, fif.out_valid}, 64'h0);
    check_output("async_out_pc", fif.out_pc, 64'h0);
    check_output("async_out_instr", {32'h0, fif.out_instr}, 64'h0);
    check_output("async_addr", fif.ireq.addr, 64'h8000_0000);
    tick();
    reset = 1'b1;
    check_output("rerelease_addr", fif.ireq.addr, 64'h8000_0000);
    check_output("rerelease_req", {63'h0, fif.ireq.valid}, 64'h1);
    apply_stimulus(1'b0, 64'h0, 1'b1, 32'h0000_0013, 1'b0);
    tick();
    apply_stimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check_output("rerelease_valid", {63'h0, fif.out_valid}, 64'h1);
    check_output("rerelease_pc", fif.out_pc, 64'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 Parameter: PCINIT, default 64'h8000_0000, PC fetched after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; all state cleared while low.
REQ-004 redirect  input  1  one-cycle pulse from execute-stage branch comparison; fetch must restart at redirect_pc.
REQ-005 redirect_pc  input  64  redirect target, valid only with redirect.
REQ-006 ireq  output  ibus_req_t  instruction bus request: valid (1), addr (64).
REQ-007 iresp  input  ibus_resp_t  instruction bus response: data_ok (1), data (32).
REQ-008 out_valid  output  1  out_pc/out_instr hold a fetched instruction for decode.
REQ-009 out_ready  input  1  decode accepts the instruction this cycle.
REQ-010 out_pc  output  64  PC of the presented instruction.
REQ-011 out_instr  output  32  presented instruction word.

Function
REQ-012 States: REQ (bus request outstanding), DISCARD (stale request outstanding, response dropped), HOLD (instruction presented to decode).
REQ-013 ireq.valid is 1 in REQ and DISCARD and 0 in HOLD; ireq.addr is the PC register and stays stable until data_ok.
REQ-014 A request, once raised, is never withdrawn or changed before data_ok.
REQ-015 In REQ with data_ok and no redirect: latch data and PC, go to HOLD; out_valid is 1 on the next cycle.
REQ-016 In HOLD: out_valid = 1; on out_ready with no redirect, PC <= PC + 4 (64-bit wrap), go to REQ next cycle.
REQ-017 In HOLD without out_ready: outputs stay unchanged.
REQ-018 Redirect in HOLD: the held instruction is dropped (out_valid 0 next cycle), PC <= redirect_pc, go to REQ; out_ready the same cycle is ignored.
REQ-019 Redirect in REQ without data_ok: store redirect_pc in a pending register, go to DISCARD.
REQ-020 Redirect in REQ with data_ok in the same cycle: drop data, PC <= redirect_pc, go to REQ.
REQ-021 In DISCARD on data_ok: drop data, PC <= pending PC, go to REQ.
REQ-022 A second redirect in DISCARD overwrites the pending PC; the last redirect wins.
REQ-023 Redirect in DISCARD with data_ok in the same cycle: PC <= the new redirect_pc.
REQ-024 redirect_pc[1:0] are forced to 0 when loaded.
REQ-025 out_valid is never 1 for an instruction fetched from a pre-redirect PC.

Reset
REQ-026 Reset low: state = REQ, PC = PCINIT, pending PC = 0, out_valid = 0, out_pc = 0, out_instr = 0.
REQ-027 Reset is asynchronous assert and synchronous release; the first request (addr PCINIT) is raised in the first cycle after release.
REQ-028 Reset mid-request abandons the outstanding request; the bus is reset with this block.

Configuration
REQ-029 Macro FETCH_PERF_EN, when defined:
- adds outputs perf_fetch (64) and perf_flush (64);
- perf_fetch counts instructions accepted by decode;
- perf_flush counts fetches dropped by REQ-018, REQ-020 or REQ-021;
- both counters reset to 0 and wrap.
REQ-030 Without FETCH_PERF_EN: neither port nor counter exists; behaviour is otherwise identical.

Structure
REQ-031 The shared pipes package holds: the state enum fetch_state_t, the PCINIT default constant, and the struct fetch_data_t (valid, pc, instr).
REQ-032 ibus_req_t and ibus_resp_t come from the common package, unchanged.
REQ-033 Single module; no sub-module is needed.

Verification
REQ-034 Reset release, data_ok returned 2 cycles after the request with data 32'h00000013, out_ready = 1 -> ireq.addr 0x80000000, then out_pc 0x80000000 / out_instr 0x00000013, then ireq.addr 0x80000004.
REQ-035 out_ready = 0 for 5 cycles in HOLD -> out_valid, out_pc and out_instr stable; ireq.valid = 0 throughout.
REQ-036 Redirect to 0x80000100 while the request for 0x80000008 is pending, data_ok 3 cycles later -> no out_valid for that data; next ireq.addr is 0x80000100.
REQ-037 Redirect to 0x80000200 in the same cycle as data_ok -> data dropped; next ireq.addr is 0x80000200.
REQ-038 Two redirects during DISCARD (0x80000300, then 0x80000400) -> next request is 0x80000400; with FETCH_PERF_EN, perf_flush increments by 1.
REQ-039 Reset asserted while in DISCARD -> outputs clear immediately; after release ireq.addr is 0x80000000.
